// File: rtl/taxi_eth_lfc_pkg.sv
// taxi_eth_lfc_pkg: shared constants, FSM state type, header snapshot and
// beat structs, and the beat formatter for 802.3 annex 31B PAUSE frames.
package taxi_eth_lfc_pkg;

  localparam logic [15:0] LFC_ETH_TYPE    = 16'h8808;
  localparam logic [15:0] LFC_OPCODE      = 16'h0001;
  localparam int          LFC_FRAME_BYTES = 60;
  localparam int          LFC_BEATS       = 8;
  localparam int          QUANTA_CYCLES   = 8;

  typedef enum logic {ST_IDLE, ST_SEND} lfc_state_t;

  typedef struct packed {
    logic [47:0] dst;
    logic [47:0] src;
    logic [15:0] eth_type;
    logic [15:0] opcode;
    logic [15:0] ptime;
  } lfc_hdr_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } lfc_beat_t;

  // Byte n of the frame lands in data[8n+7:8n]; multi-byte fields are
  // big-endian on the wire, so they appear byte-reversed in each word.
  function automatic lfc_beat_t lfc_beat(input logic [2:0] beat, input lfc_hdr_t h);
    lfc_beat_t b;
    b.data = '0;
    b.keep = 8'hFF;
    b.last = 1'b0;
    case (beat)
      3'd0: b.data = {h.src[39:32], h.src[47:40], h.dst[7:0], h.dst[15:8],
                      h.dst[23:16], h.dst[31:24], h.dst[39:32], h.dst[47:40]};
      3'd1: b.data = {h.opcode[7:0], h.opcode[15:8], h.eth_type[7:0], h.eth_type[15:8],
                      h.src[7:0], h.src[15:8], h.src[23:16], h.src[31:24]};
      3'd2: b.data = {48'h0, h.ptime[7:0], h.ptime[15:8]};
      3'd7: begin
        b.keep = 8'h0F;
        b.last = 1'b1;
      end
      default: ;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/taxi_eth_lfc_refresh_timer.sv
// taxi_eth_lfc_refresh_timer: XOFF refresh timer. A prescaler divides the
// clock into pause quanta; the quanta counter pulses expire when it reaches
// period and then restarts.
//   clk, rst : clock, synchronous active-high reset
//   run      : count enable
//   clear    : zero prescaler and counter (wins over run)
//   period   : expiry period in quanta
//   expire   : one-cycle pulse on expiry
module taxi_eth_lfc_refresh_timer
  import taxi_eth_lfc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        clear,
  input  logic [15:0] period,
  output logic        expire
);

  localparam int PW = $clog2(QUANTA_CYCLES);

  logic [PW-1:0] presc;
  logic [15:0]   cnt;
  logic [16:0]   cnt_inc;
  logic          tick;

  assign tick    = run && (presc == PW'(QUANTA_CYCLES - 1));
  assign cnt_inc = {1'b0, cnt} + 17'd1;
  // >= so that a period lowered below the running count fires on the next tick
  assign expire  = tick && !clear && (cnt_inc >= {1'b0, period});

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      presc <= '0;
      cnt   <= '0;
    end else if (run) begin
      presc <= presc + PW'(1);
      if (tick) cnt <= expire ? 16'd0 : cnt_inc[15:0];
    end
  end

endmodule

// File: rtl/taxi_eth_lfc_tx_gen.sv
// taxi_eth_lfc_tx_gen: link-level flow control PAUSE frame generator for the
// 64-bit TX AXI-stream path. Turns the tx_lfc_req level into XOFF/XON frames
// (60 bytes, no FCS) and resends XOFF every cfg_tx_lfc_refresh quanta.
//   tx_clk, tx_rst        : clock, synchronous active-high reset
//   m_axis_*              : frame output stream (tuser always 0)
//   tx_lfc_req            : pause request level
//   tx_lfc_resend         : pulse, send a frame reflecting current req
//   cfg_tx_lfc_*          : enable, addresses, type/opcode, quanta, refresh
//   stat_tx_lfc_pkt/xon/xoff : one-cycle pulses after each frame's tlast
//   busy                  : frame in flight or pending
module taxi_eth_lfc_tx_gen
  import taxi_eth_lfc_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int KEEP_W = DATA_W/8,
  parameter int USER_W = 1
) (
  input  logic              tx_clk,
  input  logic              tx_rst,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic [KEEP_W-1:0] m_axis_tkeep,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic [USER_W-1:0] m_axis_tuser,
  input  logic              tx_lfc_req,
  input  logic              tx_lfc_resend,
  input  logic              cfg_tx_lfc_en,
  input  logic [47:0]       cfg_tx_lfc_eth_dst,
  input  logic [47:0]       cfg_tx_lfc_eth_src,
  input  logic [15:0]       cfg_tx_lfc_eth_type,
  input  logic [15:0]       cfg_tx_lfc_opcode,
  input  logic [15:0]       cfg_tx_lfc_quanta,
  input  logic [15:0]       cfg_tx_lfc_refresh,
  output logic              stat_tx_lfc_pkt,
  output logic              stat_tx_lfc_xon,
  output logic              stat_tx_lfc_xoff,
  output logic              busy
);

  if (DATA_W != 64) begin : g_bad_width
    $error("taxi_eth_lfc_tx_gen supports DATA_W=64 only");
  end

  lfc_state_t state;
  logic [2:0] beat;
  logic       req_q;
  logic       pending;
  logic       snap_xoff;
  lfc_hdr_t   snap;
  lfc_hdr_t   hdr_cfg;
  lfc_hdr_t   hdr_sel;
  lfc_beat_t  nxt;
  logic       start;
  logic       accept;
  logic       expire;
  logic       evt;

  assign start  = (state == ST_IDLE) && pending && cfg_tx_lfc_en;
  assign accept = m_axis_tvalid && m_axis_tready;
  // Level changes are seen against the registered copy, so a req held high
  // through reset release looks like a rising edge.
  assign evt    = cfg_tx_lfc_en && ((tx_lfc_req ^ req_q) || tx_lfc_resend || expire);

  taxi_eth_lfc_refresh_timer u_refresh (
    .clk    (tx_clk),
    .rst    (tx_rst),
    .run    (cfg_tx_lfc_refresh != 16'd0),
    .clear  (!tx_lfc_req || (start && tx_lfc_req)),
    .period (cfg_tx_lfc_refresh),
    .expire (expire)
  );

  always_comb begin
    hdr_cfg.dst      = cfg_tx_lfc_eth_dst;
    hdr_cfg.src      = cfg_tx_lfc_eth_src;
    hdr_cfg.eth_type = cfg_tx_lfc_eth_type;
    hdr_cfg.opcode   = cfg_tx_lfc_opcode;
    hdr_cfg.ptime    = tx_lfc_req ? cfg_tx_lfc_quanta : 16'h0000;
  end

  // Beat 0 comes straight from cfg (snapshot is loaded on the same edge);
  // later beats come from the snapshot.
  assign hdr_sel = (state == ST_IDLE) ? hdr_cfg : snap;
  assign nxt     = lfc_beat((state == ST_IDLE) ? 3'd0 : beat + 3'd1, hdr_sel);

  assign m_axis_tuser = '0;
  assign busy         = (state == ST_SEND) || pending;

  always_ff @(posedge tx_clk) begin
    if (tx_rst) begin
      state            <= ST_IDLE;
      beat             <= '0;
      req_q            <= 1'b0;
      pending          <= 1'b0;
      snap_xoff        <= 1'b0;
      snap             <= '0;
      m_axis_tdata     <= '0;
      m_axis_tkeep     <= '0;
      m_axis_tvalid    <= 1'b0;
      m_axis_tlast     <= 1'b0;
      stat_tx_lfc_pkt  <= 1'b0;
      stat_tx_lfc_xon  <= 1'b0;
      stat_tx_lfc_xoff <= 1'b0;
    end else begin
      req_q            <= tx_lfc_req;
      stat_tx_lfc_pkt  <= 1'b0;
      stat_tx_lfc_xon  <= 1'b0;
      stat_tx_lfc_xoff <= 1'b0;

      // An event on the start edge stays pending so it is not lost.
      if (!cfg_tx_lfc_en) pending <= 1'b0;
      else if (evt)       pending <= 1'b1;
      else if (start)     pending <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (start) begin
            snap          <= hdr_cfg;
            snap_xoff     <= tx_lfc_req;
            beat          <= 3'd0;
            m_axis_tdata  <= nxt.data;
            m_axis_tkeep  <= nxt.keep;
            m_axis_tlast  <= nxt.last;
            m_axis_tvalid <= 1'b1;
            state         <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (accept) begin
            if (beat == 3'(LFC_BEATS - 1)) begin
              m_axis_tvalid    <= 1'b0;
              m_axis_tdata     <= '0;
              m_axis_tkeep     <= '0;
              m_axis_tlast     <= 1'b0;
              stat_tx_lfc_pkt  <= 1'b1;
              stat_tx_lfc_xoff <= snap_xoff;
              stat_tx_lfc_xon  <= !snap_xoff;
              state            <= ST_IDLE;
            end else begin
              beat         <= beat + 3'd1;
              m_axis_tdata <= nxt.data;
              m_axis_tkeep <= nxt.keep;
              m_axis_tlast <= nxt.last;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_taxi_eth_lfc_tx_gen.sv
module tb_taxi_eth_lfc_tx_gen;

  logic        clk = 1'b0;
  logic        tx_rst;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic [0:0]  m_axis_tuser;
  logic        tx_lfc_req;
  logic        tx_lfc_resend;
  logic        cfg_en;
  logic [47:0] cfg_dst, cfg_src;
  logic [15:0] cfg_type, cfg_op, cfg_quanta, cfg_refresh;
  logic        stat_pkt, stat_xon, stat_xoff, busy;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int n_pkt = 0;
  int n_vbeat = 0;
  logic [63:0] cap [8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (stat_pkt) n_pkt++;
    if (m_axis_tvalid) n_vbeat++;
  end

  taxi_eth_lfc_tx_gen dut (
    .tx_clk(clk), .tx_rst(tx_rst),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .tx_lfc_req(tx_lfc_req), .tx_lfc_resend(tx_lfc_resend),
    .cfg_tx_lfc_en(cfg_en),
    .cfg_tx_lfc_eth_dst(cfg_dst), .cfg_tx_lfc_eth_src(cfg_src),
    .cfg_tx_lfc_eth_type(cfg_type), .cfg_tx_lfc_opcode(cfg_op),
    .cfg_tx_lfc_quanta(cfg_quanta), .cfg_tx_lfc_refresh(cfg_refresh),
    .stat_tx_lfc_pkt(stat_pkt), .stat_tx_lfc_xon(stat_xon),
    .stat_tx_lfc_xoff(stat_xoff), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference frame built byte by byte, then sliced into 8-byte words.
  function automatic logic [63:0] exp_beat(input int b, input logic [47:0] dst,
                                           input logic [47:0] src, input logic [15:0] pt);
    logic [7:0] fr [64];
    logic [63:0] d;
    for (int i = 0; i < 64; i++) fr[i] = 8'h00;
    for (int i = 0; i < 6; i++) begin
      fr[i]   = dst[8*(5-i) +: 8];
      fr[6+i] = src[8*(5-i) +: 8];
    end
    fr[12] = 8'h88; fr[13] = 8'h08; fr[14] = 8'h00; fr[15] = 8'h01;
    fr[16] = pt[15:8]; fr[17] = pt[7:0];
    d = '0;
    for (int i = 0; i < 8; i++) d[8*i +: 8] = fr[8*b + i];
    return d;
  endfunction

  // Receive one frame starting at a negedge. ready_pct is the tready-high
  // probability; at beat inj the resend pulse fires and quanta is changed to
  // new_q (inj<0: no injection).
  task automatic get_frame(input string tag, input bit xoff, input logic [15:0] q,
                           input int ready_pct, input int inj, input logic [15:0] new_q,
                           output int start_cyc, output int end_cyc);
    int b, guard;
    bit injected;
    logic [63:0] ed;
    logic [8:0] ek;
    start_cyc = -1; end_cyc = -1;
    for (int t = 0; t < 60 && !m_axis_tvalid; t++) @(negedge clk);
    chk({tag, "_start"}, m_axis_tvalid, 1'b1);
    if (!m_axis_tvalid) return;
    start_cyc = cyc;
    b = 0; guard = 0; injected = 0;
    while (b < 8 && guard < 400) begin
      m_axis_tready = (ready_pct >= 100) ? 1'b1 : ($urandom_range(99) < ready_pct);
      tx_lfc_resend = 1'b0;
      if (inj >= 0 && b == inj && !injected) begin
        tx_lfc_resend = 1'b1;
        cfg_quanta = new_q;
        injected = 1;
      end
      ed = exp_beat(b, cfg_dst, cfg_src, xoff ? q : 16'h0000);
      ek = (b == 7) ? 9'h01F : 9'h1FE;
      chk({tag, "_vld"}, m_axis_tvalid, 1'b1);
      chk({tag, "_data"}, m_axis_tdata, ed);
      chk({tag, "_keeplast"}, {m_axis_tkeep, m_axis_tlast}, ek);
      cap[b] = m_axis_tdata;
      if (m_axis_tready && m_axis_tvalid) b++;
      @(negedge clk);
      guard++;
    end
    tx_lfc_resend = 1'b0;
    m_axis_tready = 1'b1;
    end_cyc = cyc;
    chk({tag, "_beats"}, b, 8);
    chk({tag, "_gap_vld"}, m_axis_tvalid, 1'b0);
    chk({tag, "_stat"}, {stat_pkt, stat_xoff, stat_xon}, {1'b1, xoff, !xoff});
  endtask

  int s1, s2, s3, e1, e2, e3, pk, vb;

  initial begin
    tx_rst = 1'b1; m_axis_tready = 1'b1; tx_lfc_req = 1'b0; tx_lfc_resend = 1'b0;
    cfg_en = 1'b1; cfg_dst = 48'h0180C2000001; cfg_src = 48'h0200000000AA;
    cfg_type = 16'h8808; cfg_op = 16'h0001; cfg_quanta = 16'hFFFF; cfg_refresh = 16'd0;
    repeat (3) @(negedge clk);
    chk("rst_outs", {m_axis_tvalid, m_axis_tlast, m_axis_tkeep, stat_pkt, stat_xon, stat_xoff, busy}, '0);
    chk("rst_data", m_axis_tdata, 64'h0);
    chk("rst_user", m_axis_tuser, 1'b0);
    tx_rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_vld", m_axis_tvalid, 1'b0);

    // XOFF on assert, with start latency check
    tx_lfc_req = 1'b1;
    @(negedge clk);
    chk("lat_pend_busy", busy, 1'b1);
    chk("lat_vld_k", m_axis_tvalid, 1'b0);
    @(negedge clk);
    chk("lat_vld_k1", m_axis_tvalid, 1'b1);
    get_frame("xoff", 1'b1, 16'hFFFF, 100, -1, 16'h0, s1, e1);
    chk("xoff_b0", cap[0], 64'h0002010000C28001);
    chk("xoff_b1", cap[1], 64'h01000888AA000000);
    chk("xoff_b2", cap[2], 64'h000000000000FFFF);
    vb = n_vbeat;
    repeat (60) @(negedge clk);
    chk("norefresh_quiet", n_vbeat - vb, 0);

    // XON on deassert
    tx_lfc_req = 1'b0;
    get_frame("xon", 1'b0, 16'hFFFF, 100, -1, 16'h0, s1, e1);
    chk("xon_b2", cap[2], 64'h0);

    // Refresh every 2 quanta: start-to-start = 8 + 8 prescaled cycles + 1
    cfg_refresh = 16'd2; cfg_quanta = 16'h00A0;
    tx_lfc_req = 1'b1;
    get_frame("ref1", 1'b1, 16'h00A0, 100, -1, 16'h0, s1, e1);
    get_frame("ref2", 1'b1, 16'h00A0, 100, -1, 16'h0, s2, e2);
    get_frame("ref3", 1'b1, 16'h00A0, 100, -1, 16'h0, s3, e3);
    chk("ref_period12", s2 - s1, 17);
    chk("ref_period23", s3 - s2, 17);
    cfg_refresh = 16'd0;
    tx_lfc_req = 1'b0;
    get_frame("ref_xon", 1'b0, 16'h00A0, 100, -1, 16'h0, s1, e1);

    // Backpressure 30% ready, resend + quanta change mid-frame
    cfg_quanta = 16'h1234;
    tx_lfc_req = 1'b1;
    get_frame("bp", 1'b1, 16'h1234, 30, 1, 16'h5555, s1, e1);
    get_frame("bp_extra", 1'b1, 16'h5555, 100, -1, 16'h0, s2, e2);
    chk("bp_gap", s2 - e1, 1);
    vb = n_vbeat;
    repeat (30) @(negedge clk);
    chk("bp_one_extra", n_vbeat - vb, 0);

    // Disable: no frames while req toggles and resend pulses
    cfg_en = 1'b0;
    vb = n_vbeat;
    for (int i = 0; i < 4; i++) begin
      tx_lfc_req = ~tx_lfc_req;
      repeat (5) @(negedge clk);
    end
    tx_lfc_resend = 1'b1; @(negedge clk); tx_lfc_resend = 1'b0;
    repeat (5) @(negedge clk);
    chk("dis_busy", busy, 1'b0);
    cfg_en = 1'b1;
    repeat (20) @(negedge clk);
    chk("dis_no_frames", n_vbeat - vb, 0);

    // Reset at beat 4, with req held high across release
    tx_lfc_resend = 1'b1; @(negedge clk); tx_lfc_resend = 1'b0;
    for (int t = 0; t < 10 && !m_axis_tvalid; t++) @(negedge clk);
    repeat (4) @(negedge clk);
    chk("mid_beat4", m_axis_tdata, exp_beat(4, cfg_dst, cfg_src, 16'h0));
    pk = n_pkt;
    tx_rst = 1'b1; tx_lfc_req = 1'b1;
    @(negedge clk);
    chk("mid_rst_vld", m_axis_tvalid, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    @(negedge clk);
    tx_rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_rst_nostat", n_pkt - pk, 0);
    get_frame("rel_xoff", 1'b1, 16'h5555, 100, -1, 16'h0, s1, e1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout vectors=%0d", vectors);
    $fatal(1, "timeout");
  end

endmodule
